// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch digit chain.
// The terminal-value helper is used by both the RTL and its checkers.
// Default build: no optional features live here.
package stopwatch_pkg;

    localparam int DIGIT_W_DEF = 4;

    typedef logic [DIGIT_W_DEF-1:0] digit_t;

    // MM:SS limits, digit 0 in the LSBs: 9, 5, 9, 5
    localparam logic [4*DIGIT_W_DEF-1:0] MMSS_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

    function automatic logic term_f(input digit_t value, input digit_t max_v, input logic up);
        return up ? (value == max_v) : (value == '0);
    endfunction

endpackage

// File: rtl/mod_digit.sv
// Single modulo up/down digit with clear, clamped load and terminal flag.
// Latency: one clock from step/clr/load to value; term is combinational.
// Backpressure: none; a step is always accepted on the edge it is seen.
module mod_digit
    import stopwatch_pkg::*;
#(
    parameter int W = DIGIT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] value,
    output logic         term
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    generate
        if (W == DIGIT_W_DEF) begin : g_pkg_term
            assign term = term_f(value_q, max_val, up);
        end else begin : g_inline_term
            assign term = up ? (value_q == max_val) : (value_q == '0);
        end
    endgenerate

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = (load_val > max_val) ? max_val : load_val;
        end else if (step) begin
            if (up) begin
                // An out-of-range digit re-enters the legal range at zero
                value_d = (term || (value_q > max_val)) ? '0 : value_q + 1'b1;
            end else begin
                value_d = term ? max_val : value_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/updown_digit_chain.sv
// Cascaded up/down modulo digit counter with per-digit max; optional lap freeze (LAP_LATCH_EN).
// Latency: digits one clock after en/clr/load; tc same cycle; wrap one cycle after the wrapping edge.
// Backpressure: none; every en tick is consumed, clr > load > en on each edge.
module updown_digit_chain
    import stopwatch_pkg::*;
#(
    parameter int                              NUM_DIGITS = 4,
    parameter int                              DIGIT_W    = DIGIT_W_DEF,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DIGIT_MAX  = MMSS_MAX
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            up,
    input  logic                            clr,
    input  logic                            load,
`ifdef LAP_LATCH_EN
    input  logic                            lap,
`endif
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
    output logic                            tc,
    output logic                            wrap
);

    logic [NUM_DIGITS-1:0]         step;
    logic [NUM_DIGITS-1:0]         term;
    logic [NUM_DIGITS*DIGIT_W-1:0] live;
    logic                          wrap_q;
    logic                          wrap_d;

    assign step[0] = en;

    genvar k;
    generate
        for (k = 1; k < NUM_DIGITS; k++) begin : g_step
            assign step[k] = step[k-1] & term[k-1];
        end
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            mod_digit #(.W(DIGIT_W)) u_digit (
                .clk      (clk),
                .rst_n    (rst_n),
                .step     (step[k]),
                .up       (up),
                .clr      (clr),
                .load     (load),
                .load_val (load_val[k*DIGIT_W +: DIGIT_W]),
                .max_val  (DIGIT_MAX[k*DIGIT_W +: DIGIT_W]),
                .value    (live[k*DIGIT_W +: DIGIT_W]),
                .term     (term[k])
            );
        end
    endgenerate

    // tc deliberately ignores clr/load; only the registered wrap is gated
    assign tc     = en & (&term);
    assign wrap_d = en & ~clr & ~load & (&term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

`ifdef LAP_LATCH_EN
    logic                          lap_q;
    logic                          frozen_q;
    logic                          frozen_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_q;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_d;

    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (clr) begin
            frozen_d = 1'b0;
        end else if (lap & ~lap_q) begin
            frozen_d = ~frozen_q;
            snap_d   = live;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q    <= 1'b0;
            frozen_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            lap_q    <= lap;
            frozen_q <= frozen_d;
            snap_q   <= snap_d;
        end
    end

    assign digits = frozen_q ? snap_q : live;
`else
    assign digits = live;
`endif

endmodule

// File: tb/tb_updown_digit_chain.sv
// Self-checking bench for updown_digit_chain with default MM:SS limits.
// Lap checks are compiled in when LAP_LATCH_EN is defined.
module tb_updown_digit_chain;

    localparam int NMOD = 3600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] digits;
    logic        tc;
    logic        wrap;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;
    int tc_ones = 0;
    int rad [4] = '{10, 6, 10, 6};

    updown_digit_chain dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
`ifdef LAP_LATCH_EN
        .lap      (lap),
`endif
        .load_val (load_val),
        .digits   (digits),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] lv;
        logic        exp_tc;
        logic [15:0] exp_d;
        logic        exp_wrap;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mixed-radix count -> packed digits
    function automatic logic [15:0] enc(input int c);
        logic [15:0] d;
        int r;
        d = '0;
        r = c;
        for (int k = 0; k < 4; k++) begin
            d[k*4 +: 4] = 4'(r % rad[k]);
            r = r / rad[k];
        end
        return d;
    endfunction

    function automatic int dec_clamp(input logic [15:0] v);
        int c;
        int w;
        int dv;
        c = 0;
        w = 1;
        for (int k = 0; k < 4; k++) begin
            dv = int'(v[k*4 +: 4]);
            if (dv > rad[k] - 1) dv = rad[k] - 1;
            c = c + dv * w;
            w = w * rad[k];
        end
        return c;
    endfunction

    // One clock against the model: tc before the edge, digits/wrap after it
    task automatic cycle(input logic c_clr, input logic c_load, input logic c_en,
                         input logic c_up, input logic [15:0] c_lv, input bit chk_d);
        logic exp_wrap;
        logic exp_tc;
        clr = c_clr; load = c_load; en = c_en; up = c_up; load_val = c_lv;
        #1;
        exp_tc = c_en && (c_up ? (cnt == NMOD - 1) : (cnt == 0));
        chk("tc", {31'd0, tc}, {31'd0, exp_tc});
        if (tc === 1'b1) tc_ones++;
        @(posedge clk);
        exp_wrap = 1'b0;
        if (c_clr) begin
            cnt = 0;
        end else if (c_load) begin
            cnt = dec_clamp(c_lv);
        end else if (c_en) begin
            if (c_up) begin
                exp_wrap = (cnt == NMOD - 1);
                cnt = (cnt + 1) % NMOD;
            end else begin
                exp_wrap = (cnt == 0);
                cnt = (cnt + NMOD - 1) % NMOD;
            end
        end
        #1;
        if (chk_d) chk("digits", {16'd0, digits}, {16'd0, enc(cnt)});
        chk("wrap", {31'd0, wrap}, {31'd0, exp_wrap});
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0959, 1'b0, 16'h0959, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0959, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5959, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h7989, 1'b1, 16'h5959, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0059, 1'b0, 16'h0059, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0100, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0059, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0A0B, 1'b0, 16'h0909, 1'b0};

        // Reset state; tc is live even in reset (down at zero with en)
        en = 1'b1; up = 1'b0;
        #1;
        chk("rst_digits", {16'd0, digits}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_tc", {31'd0, tc}, 32'd1);
        en = 1'b0; up = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            clr = tbl[i].clr; load = tbl[i].load; en = tbl[i].en;
            up = tbl[i].up; load_val = tbl[i].lv;
            #1;
            chk($sformatf("tbl%0d_tc", i), {31'd0, tc}, {31'd0, tbl[i].exp_tc});
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_digits", i), {16'd0, digits}, {16'd0, tbl[i].exp_d});
            chk($sformatf("tbl%0d_wrap", i), {31'd0, wrap}, {31'd0, tbl[i].exp_wrap});
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
        cnt = dec_clamp(16'h0909);

        // Asynchronous reset between edges at 12:34
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digits", {16'd0, digits}, 32'd0);
        chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1);
        chk("resume_0001", {16'd0, digits}, 32'h0001);

        // Full hour counting up
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        tc_ones = 0;
        for (int i = 1; i <= NMOD; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1);
            if (i == 59)   chk("at_0059", {16'd0, digits}, 32'h0059);
            if (i == 60)   chk("at_0100", {16'd0, digits}, 32'h0100);
            if (i == NMOD) begin
                chk("hour_digits", {16'd0, digits}, 32'h0000);
                chk("hour_wrap", {31'd0, wrap}, 32'd1);
            end
        end
        chk("tc_once", tc_ones, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);

        // Randomised traffic against the arithmetic model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0,
                  ($urandom % 4) != 0, 16'($urandom), 1'b1);
        end

`ifdef LAP_LATCH_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 1'b1);
        lap = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        lap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
            chk("lap_frozen", {16'd0, digits}, 32'h0010);
        end
        lap = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        lap = 1'b0;
        chk("lap_release", {16'd0, digits}, 32'h0015);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
